// File: rtl/ibex_fp_fma_seq_if.sv
// Request, FPU-mux and result signals of the bf16 FMA sequencer.
// slave = sequencer side, master = pipeline/FPU/writeback side.
interface ibex_fp_fma_seq_if #(
  parameter int OpW = 4
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic [1:0]      req_op_i;
  logic [15:0]     operand_a_i;
  logic [15:0]     operand_b_i;
  logic [15:0]     operand_c_i;
  logic            kill_i;
  logic            fpu_sel_o;
  logic [OpW-1:0]  fpu_op_o;
  logic [31:0]     fpu_operand_a_o;
  logic [15:0]     fpu_operand_b_o;
  logic [31:0]     fpu_result_i;
  logic            result_valid_o;
  logic            result_ready_i;
  logic [31:0]     result_o;
  logic            busy_o;

  modport slave (
    input  req_valid_i, req_op_i, operand_a_i, operand_b_i, operand_c_i,
    input  kill_i, fpu_result_i, result_ready_i,
    output req_ready_o, fpu_sel_o, fpu_op_o, fpu_operand_a_o, fpu_operand_b_o,
    output result_valid_o, result_o, busy_o
  );

  modport master (
    output req_valid_i, req_op_i, operand_a_i, operand_b_i, operand_c_i,
    output kill_i, fpu_result_i, result_ready_i,
    input  req_ready_o, fpu_sel_o, fpu_op_o, fpu_operand_a_o, fpu_operand_b_o,
    input  result_valid_o, result_o, busy_o
  );
endinterface

// File: rtl/ibex_fp_fma_seq.sv
// bf16 FMA-family sequencer: multiply then add/sub on the shared FPU.
// Optional perf counters enabled by defining IBEX_FMA_SEQ_PERF_EN.
module ibex_fp_fma_seq #(
  parameter int             OpW     = 4,
  parameter logic [OpW-1:0] FpOpAdd = OpW'(0),
  parameter logic [OpW-1:0] FpOpSub = OpW'(1),
  parameter logic [OpW-1:0] FpOpMul = OpW'(2)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ibex_fp_fma_seq_if.slave    bus
`ifdef IBEX_FMA_SEQ_PERF_EN
  ,
  output logic [31:0]         perf_ops_o,
  output logic [15:0]         perf_kills_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ADD, S_DONE} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [1:0]  r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_c;
  logic [15:0] r_prod;
  logic [31:0] r_result;
  logic        w_accept;
  logic        w_unused_fpu_lsbs;

  assign w_unused_fpu_lsbs = ^bus.fpu_result_i[15:0];

  assign bus.req_ready_o    = (r_state == S_IDLE) ||
                              ((r_state == S_DONE) && bus.result_ready_i);
  // kill wins over an accept even though ready still reads high
  assign w_accept           = bus.req_valid_i && bus.req_ready_o && !bus.kill_i;
  assign bus.result_valid_o = (r_state == S_DONE);
  assign bus.result_o       = r_result;
  assign bus.busy_o         = (r_state != S_IDLE);

  always_comb begin
    w_state_next        = r_state;
    bus.fpu_sel_o       = 1'b0;
    bus.fpu_op_o        = FpOpAdd;
    bus.fpu_operand_a_o = 32'h0;
    bus.fpu_operand_b_o = 16'h0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_MUL;
      S_MUL: begin
        bus.fpu_sel_o       = 1'b1;
        bus.fpu_op_o        = FpOpMul;
        bus.fpu_operand_a_o = {r_a, 16'h0};
        bus.fpu_operand_b_o = r_b;
        w_state_next        = S_ADD;
      end
      S_ADD: begin
        bus.fpu_sel_o       = 1'b1;
        bus.fpu_op_o        = r_op[0] ? FpOpSub : FpOpAdd;
        bus.fpu_operand_a_o = {r_prod, 16'h0};
        bus.fpu_operand_b_o = r_c;
        w_state_next        = S_DONE;
      end
      S_DONE: if (bus.result_ready_i) w_state_next = w_accept ? S_MUL : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (bus.kill_i) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_op     <= 2'd0;
      r_a      <= 16'h0;
      r_b      <= 16'h0;
      r_c      <= 16'h0;
      r_prod   <= 16'h0;
      r_result <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op <= bus.req_op_i;
        r_a  <= bus.operand_a_i;
        r_b  <= bus.operand_b_i;
        r_c  <= bus.operand_c_i;
      end
      // negated-product ops (FNMSUB/FNMADD) flip the product sign here
      if (r_state == S_MUL)
        r_prod <= {bus.fpu_result_i[31] ^ r_op[1], bus.fpu_result_i[30:16]};
      if ((r_state == S_ADD) && !bus.kill_i)
        r_result <= {bus.fpu_result_i[31:16], 16'h0};
    end
  end

`ifdef IBEX_FMA_SEQ_PERF_EN
  logic [31:0] r_perf_ops;
  logic [15:0] r_perf_kills;
  logic        w_handshake;

  assign w_handshake = (r_state == S_DONE) && bus.result_ready_i && !bus.kill_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_ops   <= 32'h0;
      r_perf_kills <= 16'h0;
    end else begin
      if (w_handshake && (r_perf_ops != 32'hFFFF_FFFF))
        r_perf_ops <= r_perf_ops + 32'd1;
      if (bus.kill_i && bus.busy_o && (r_perf_kills != 16'hFFFF))
        r_perf_kills <= r_perf_kills + 16'd1;
    end
  end

  assign perf_ops_o   = r_perf_ops;
  assign perf_kills_o = r_perf_kills;
`endif

endmodule
